// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues word reads over req/ack,
// and buffers {instr, pc} in a DEPTH-entry prefetch FIFO. Optional FETCH_PERF_EN adds counters.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              instr_pc_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              fetch_cnt_o,
    output logic [31:0]              stall_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    pc_q   [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count_q, count_nxt;
    logic           push, pop;

    assign push          = mem_req_o && mem_ack_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign count_nxt     = count_q + CW'(push) - CW'(pop);
    assign mem_addr_o    = fetch_pc;
    assign count_o       = count_q;
    assign instr_valid_o = (count_q != '0);
    // Gate the head to zero while empty so the outputs read 0 out of reset.
    assign instr_o       = instr_valid_o ? data_q[rd_ptr] : '0;
    assign instr_pc_o    = instr_valid_o ? pc_q[rd_ptr]   : '0;

    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !redirect_i) begin
            data_q[wr_ptr] <= mem_rdata_i;
            pc_q[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
        end else if (redirect_i) begin
            // Flush wins over any same-cycle ack or pop.
            fetch_pc <= redirect_pc_i & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            if (state != IDLE) begin
                state     <= FETCH;
                mem_req_o <= 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            case (state)
                IDLE: if (start_i) begin
                    state     <= FETCH;
                    mem_req_o <= 1'b1;
                end
                FETCH: if (count_nxt == CW'(DEPTH)) begin
                    state     <= FULL;
                    mem_req_o <= 1'b0;
                end
                FULL: if (count_nxt < CW'(DEPTH)) begin
                    state     <= FETCH;
                    mem_req_o <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (push && !redirect_i)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (state == FULL)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4); memory returns addr|0xA500_0000.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, start, redirect, mem_req, mem_ack, instr_valid, ready;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, instr, instr_pc;
    logic [2:0]  count;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr | 32'hA500_0000;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .instr_valid_o(instr_valid),
        .instr_o(instr), .instr_pc_o(instr_pc), .instr_ready_i(ready), .count_o(count)
`ifdef FETCH_PERF_EN
        , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; start = 0; redirect = 0; redirect_pc = 0; mem_ack = 0; ready = 0;
        step(); step();
        rst = 0;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_count", 32'(count), 0);

        // 1: zero-wait streaming with ready held high
        mem_ack = 1; ready = 1; start = 1;
        step(); start = 0;
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_addr0", mem_addr, 32'h0);
        chk("t1_valid0", 32'(instr_valid), 0);
        step();
        chk("t1_addr4", mem_addr, 32'h4);
        chk("t1_valid", 32'(instr_valid), 1);
        chk("t1_hpc", instr_pc, 32'h0);
        chk("t1_hinstr", instr, 32'hA500_0000);
        step();
        chk("t1_addr8", mem_addr, 32'h8);
        chk("t1_hpc4", instr_pc, 32'h4);
        chk("t1_cnt", 32'(count), 1);

        // 2: fill to DEPTH with decode stalled
        mem_ack = 0; ready = 0; redirect = 1; redirect_pc = 32'h0;
        step(); redirect = 0;
        chk("t2_flush", 32'(count), 0);
        chk("t2_addr", mem_addr, 32'h0);
        mem_ack = 1;
        step(); step(); step(); step();
        chk("t2_full_cnt", 32'(count), 4);
        chk("t2_full_req", 32'(mem_req), 0);
        step();
        chk("t2_hold_cnt", 32'(count), 4);
        chk("t2_hold_req", 32'(mem_req), 0);
        chk("t2_head", instr_pc, 32'h0);
        ready = 1;
        step(); ready = 0;
        chk("t2_pop_cnt", 32'(count), 3);
        chk("t2_pop_head", instr_pc, 32'h4);
        chk("t2_rereq", 32'(mem_req), 1);
        chk("t2_readdr", mem_addr, 32'h10);

        // 3: redirect with a same-cycle ack at count 3
        redirect = 1; redirect_pc = 32'h103;
        step(); redirect = 0; mem_ack = 0;
        chk("t3_cnt", 32'(count), 0);
        chk("t3_valid", 32'(instr_valid), 0);
        chk("t3_addr", mem_addr, 32'h100);
        chk("t3_req", 32'(mem_req), 1);
        mem_ack = 1;
        step(); mem_ack = 0;
        chk("t3_hpc", instr_pc, 32'h100);
        chk("t3_hinstr", instr, 32'hA500_0100);
        ready = 1;
        step(); ready = 0;
        chk("t3_drain", 32'(count), 0);

        // 4: 3 wait cycles before ack; ready while empty is harmless
        ready = 1;
        step();
        chk("t4_w1", mem_addr, 32'h104);
        step();
        chk("t4_w2", mem_addr, 32'h104);
        ready = 0;
        step();
        chk("t4_w3", mem_addr, 32'h104);
        chk("t4_w3_cnt", 32'(count), 0);
        mem_ack = 1;
        step(); mem_ack = 0;
        chk("t4_cnt", 32'(count), 1);
        chk("t4_addr", mem_addr, 32'h108);
        step();
        chk("t4_cnt2", 32'(count), 1);
        chk("t4_addr2", mem_addr, 32'h108);

        // 5: simultaneous push and pop at count 2
        mem_ack = 1;
        step();
        chk("t5_cnt2", 32'(count), 2);
        ready = 1;
        step();
        chk("t5_pp_cnt", 32'(count), 2);
        chk("t5_pp_head", instr_pc, 32'h108);
        step();
        chk("t5_pp_cnt2", 32'(count), 2);
        chk("t5_pp_head2", instr_pc, 32'h10C);
        chk("t5_pp_instr", instr, 32'hA500_010C);
        mem_ack = 0; ready = 0;

        // PC wrap at the top of the address space
        redirect = 1; redirect_pc = 32'hFFFF_FFFE;
        step(); redirect = 0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack = 1;
        step();
        chk("wrap_next", mem_addr, 32'h0);
        chk("wrap_hpc", instr_pc, 32'hFFFF_FFFC);

        // 6: reset mid-fetch with ack high
        chk("t6_pre_req", 32'(mem_req), 1);
        rst = 1;
        step(); rst = 0;
        chk("t6_req", 32'(mem_req), 0);
        chk("t6_addr", mem_addr, 32'h0);
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_cnt", 32'(count), 0);
        chk("t6_instr", instr, 0);
        chk("t6_pc", instr_pc, 0);
`ifdef FETCH_PERF_EN
        chk("t6_fcnt", fetch_cnt, 0);
        chk("t6_scnt", stall_cnt, 0);
`endif
        step(); step();
        chk("t6_idle_req", 32'(mem_req), 0);
        chk("t6_idle_cnt", 32'(count), 0);
        start = 1;
        step(); start = 0;
        chk("t6_restart", 32'(mem_req), 1);
        mem_ack = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
